// File: rtl/status_pkg.sv
// Shared types and constants for the status transmitter and collector.
package status_pkg;
    localparam int N_BITS = 18;
    localparam int IDX_W  = 6;

    typedef logic [N_BITS-1:0] status_t;
    typedef logic [IDX_W-1:0]  idx_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } tx_state_t;
endpackage

// File: rtl/status_tx_if.sv
// Load/stream bundle between a status_tx and the logic around it.
interface status_tx_if;
    import status_pkg::*;

    status_t status_i;
    logic    load_i;
    logic    busy_o;
    idx_t    data_o;
    logic    data_val_o;
    logic    ready_i;
    logic    done_o;

    modport slave (
        input  status_i, load_i, ready_i,
        output busy_o, data_o, data_val_o, done_o
    );

    modport master (
        output status_i, load_i, ready_i,
        input  busy_o, data_o, data_val_o, done_o
    );
endinterface

// File: rtl/status_prio_enc.sv
// Combinational lowest-set-bit encoder returning a 1-based index and a found flag.
module status_prio_enc
    import status_pkg::*;
(
    input  status_t vec_i,
    output idx_t    idx_o,
    output logic    found_o
);

    // Scanning from the top lets the lowest set bit win the last assignment.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = N_BITS - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = IDX_W'(i + 1);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/status_tx.sv
// Serialises the set bits of a captured status vector as 1-based indices, lowest first.
// Build option: STATUS_TX_GAP_EN inserts one idle cycle after every non-final beat.
module status_tx
    import status_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    status_tx_if.slave  bus
);

    tx_state_t state_q, state_d;
    status_t   pend_q, pend_d;
    status_t   pend_rest;
    idx_t      enc_idx;
    logic      enc_found;
    logic      gap_q;
    logic      data_val;
    logic      accept;

    status_prio_enc u_enc (
        .vec_i   (pend_q),
        .idx_o   (enc_idx),
        .found_o (enc_found)
    );

    // Clearing the lowest set bit: x & (x - 1).
    assign pend_rest = pend_q & (pend_q - status_t'(1));

    assign data_val = (state_q == SEND) && enc_found && !gap_q;
    assign accept   = data_val && bus.ready_i;

    assign bus.busy_o     = (state_q == SEND);
    assign bus.done_o     = (state_q == DONE);
    assign bus.data_val_o = data_val;
    assign bus.data_o     = data_val ? enc_idx : '0;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.load_i) begin
                    pend_d  = bus.status_i;
                    state_d = (bus.status_i != '0) ? SEND : DONE;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (accept) begin
                    pend_d = pend_rest;
                    if (pend_rest == '0) begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

`ifdef STATUS_TX_GAP_EN
    logic gap_d;

    // No bubble follows the final beat; DONE comes straight after it.
    assign gap_d = accept && (pend_rest != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gap_q <= 1'b0;
        end else begin
            gap_q <= gap_d;
        end
    end
`else
    assign gap_q = 1'b0;
`endif

endmodule

// File: tb/tb_status_tx.sv
// Randomised bench for status_tx against a queue-based model of the index stream.
module tb_status_tx;
    import status_pkg::*;

`ifdef STATUS_TX_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    status_tx_if bus ();

    status_tx dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model: indices still to be sent, pending done pulse, pending bubble.
    int q[$];
    bit done_m = 1'b0;
    bit gap_m  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit was_busy;
        bit acc;
        bit nd;
        bit ng;
        if (rst_i) begin
            q.delete();
            done_m = 1'b0;
            gap_m  = 1'b0;
        end else begin
            was_busy = (q.size() > 0);
            acc = was_busy && !gap_m && bus.ready_i;
            nd = 1'b0;
            ng = 1'b0;
            if (acc) begin
                void'(q.pop_front());
                if (q.size() == 0) nd = 1'b1;
                else ng = GAP;
            end
            if (!was_busy && bus.load_i) begin
                for (int b = 0; b < N_BITS; b++)
                    if (bus.status_i[b]) q.push_back(b + 1);
                if (q.size() == 0) nd = 1'b1;
            end
            done_m = nd;
            gap_m  = ng;
        end
    end

    always @(negedge clk) begin
        bit vm;
        if (chk_en) begin
            vm = (q.size() > 0) && !gap_m;
            chk("busy_o", bus.busy_o, (q.size() > 0));
            chk("data_val_o", bus.data_val_o, vm);
            chk("data_o", bus.data_o, vm ? q[0] : 0);
            chk("done_o", bus.done_o, done_m);
        end
    end

    task automatic do_load(input status_t v);
        bus.status_i = v;
        bus.load_i   = 1'b1;
        @(negedge clk);
        bus.load_i   = 1'b0;
        bus.status_i = status_t'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus.busy_o || bus.done_o) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle: busy still %0d after %0d cycles", bus.busy_o, n);
        end
    endtask

    initial begin
        status_t v;
        rst_i        = 1'b1;
        bus.load_i   = 1'b0;
        bus.ready_i  = 1'b1;
        bus.status_i = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_val", bus.data_val_o, 0);
        chk("rst_data", bus.data_o, 0);
        chk("rst_done", bus.done_o, 0);
        rst_i = 1'b0;
        @(negedge clk);

        // Two set bits, sink always ready.
        do_load(18'h00005);
        chk("t1_beat1", bus.data_o, 1);
        @(negedge clk);
        if (GAP) begin
            chk("t1_bubble", bus.data_val_o, 0);
            @(negedge clk);
        end
        chk("t1_beat2", bus.data_o, 3);
        @(negedge clk);
        chk("t1_done", bus.done_o, 1);
        chk("t1_busy", bus.busy_o, 0);
        @(negedge clk);

        // Every bit set.
        do_load(18'h3FFFF);
        for (int i = 1; i <= N_BITS; i++) begin
            chk("t2_beat", bus.data_o, i);
            @(negedge clk);
            if (GAP && i < N_BITS) @(negedge clk);
        end
        chk("t2_done", bus.done_o, 1);
        wait_idle();

        // Back-pressure holds the beat steady.
        bus.ready_i = 1'b0;
        do_load(18'h20001);
        for (int i = 0; i < 4; i++) begin
            chk("t3_hold", bus.data_o, 1);
            @(negedge clk);
        end
        bus.ready_i = 1'b1;
        @(negedge clk);
        if (GAP) @(negedge clk);
        chk("t3_beat2", bus.data_o, 18);
        wait_idle();

        // Empty vector, then a load attempted mid-transfer.
        do_load(18'h00000);
        chk("t4_done", bus.done_o, 1);
        chk("t4_val", bus.data_val_o, 0);
        @(negedge clk);
        do_load(18'h000F0);
        chk("t4_first", bus.data_o, 5);
        do_load(18'h00001);
        wait_idle();

        // Reset in the middle of a transfer.
        do_load(18'h000FF);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("t5_busy", bus.busy_o, 0);
        chk("t5_val", bus.data_val_o, 0);
        chk("t5_data", bus.data_o, 0);
        chk("t5_done", bus.done_o, 0);
        @(negedge clk);
        chk("t5_nodone", bus.done_o, 0);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            bus.ready_i = ($urandom_range(0, 3) != 0);
            bus.load_i  = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0: v = '0;
                1: v = status_t'(1) << $urandom_range(0, N_BITS - 1);
                default: v = status_t'($urandom);
            endcase
            bus.status_i = v;
            rst_i = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        rst_i       = 1'b0;
        bus.load_i  = 1'b0;
        bus.ready_i = 1'b1;
        @(negedge clk);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/status_tx.md
# status_tx

Transmit-side counterpart of the status collector. Captures an 18-bit status vector on request and serialises every set bit as a 1-based index (1..18) on a 6-bit data/valid stream, lowest bit first. Its stream output drives the collector's `data_i`/`data_val_i` port, and it adds a `ready_i` back-pressure input.

## Interface
- `N_BITS`, default 18: status vector width; indices emitted are 1..N_BITS.
- `IDX_W`, default 6: index width; must satisfy 2^IDX_W > N_BITS.
- `clk_i`, in, 1: single clock, all logic on rising edge.
- `rst_i`, in, 1: synchronous, active-high reset.
- `status_i`, in, N_BITS: vector to transmit; sampled only on an accepted load.
- `load_i`, in, 1: load request; accepted only while `busy_o`=0.
- `busy_o`, out, 1: transmission in progress.
- `data_o`, out, IDX_W: current index (bit position + 1); 0 when `data_val_o`=0.
- `data_val_o`, out, 1: `data_o` valid.
- `ready_i`, in, 1: sink accepts the current beat.
- `done_o`, out, 1: one-cycle pulse when the captured vector is fully sent.

## Operation
- FSM states:
  - IDLE: `busy_o`=0.
    - `load_i`=1 latches `status_i` into the shadow register `pend`.
    - If `status_i` is non-zero, go to SEND; else go to DONE.
  - SEND: `busy_o`=1.
    - `data_o` = priority-encoded lowest set bit of `pend`, plus 1. `data_val_o`=1.
    - A beat is accepted on a clock edge where `data_val_o` & `ready_i` = 1. On acceptance, clear that bit in `pend`.
    - If the cleared bit was the last one set, go to DONE.
  - DONE: `done_o`=1 and `busy_o`=0 for exactly one cycle, then IDLE. `load_i` is already accepted in this cycle.
- Handshake rules:
  - While `data_val_o`=1 and `ready_i`=0, `data_o` stays stable. `pend` changes only on acceptance.
  - `data_val_o` never drops without an acceptance, except on reset.
- Ignored inputs:
  - `load_i` during SEND.
  - Changes on `status_i` outside the accepting cycle.
- Arithmetic: index = bit position + 1, computed at IDX_W width with no wrap. Bit N_BITS-1 yields N_BITS.
- Reset, including mid-transfer:
  - Synchronously forces IDLE and clears `pend`.
  - All outputs go to 0: `busy_o`, `data_o`, `data_val_o`, `done_o`.
  - No `done_o` is pulsed for the aborted vector.

## Timing
- Load accepted at edge k → `busy_o`=1 and first `data_val_o`=1 in cycle k+1, i.e. 1-cycle latency.
- With `ready_i` held at 1, throughput is one index per cycle. A vector with P set bits emits beats in cycles k+1..k+P, and `done_o` is high in cycle k+P+1.
- All-zero load at edge k: no beats, `done_o` high in cycle k+1.
- `data_o` and `data_val_o` are combinational from registers only (`pend` and state). There is no input-to-output combinational path except none; `ready_i` affects only the next state.

## Configuration
- `STATUS_TX_GAP_EN`:
  - Defined: after each accepted beat, one bubble cycle is inserted with `data_val_o`=0 and `data_o`=0. A P-bit vector loaded at edge k with `ready_i`=1 finishes with `done_o` in cycle k+2P.
  - Undefined: back-to-back beats as above.

## Structure
- Shared package `status_pkg` holds:
  - `N_BITS` and `IDX_W` constants;
  - `status_t` typedef (logic [N_BITS-1:0]);
  - `idx_t` typedef (logic [IDX_W-1:0]);
  - FSM enum `tx_state_t` {IDLE, SEND, DONE}.
- One sub-module, `status_prio_enc`: purely combinational lowest-set-bit encoder. It takes a `status_t` and returns `idx_t` (1-based) plus a `found` flag.

## Test plan
- Load 18'h00005 with `ready_i`=1 → `data_o` 1 then 3 in consecutive cycles, then `done_o` for 1 cycle, `busy_o` 0.
- Load 18'h3FFFF with `ready_i`=1 → 18 consecutive beats 1..18, `done_o` in cycle k+19.
- Load 18'h20001; hold `ready_i`=0 for 4 cycles → `data_o`=1 stable for 4 cycles, then 18 after acceptance.
- Load 18'h0 → no `data_val_o`; `done_o` in cycle k+1. Repeat `load_i` during SEND with a different vector → that load is ignored and the original bits are sent.
- Assert `rst_i` after 2 beats of 18'h000FF → next cycle all outputs are 0, state is IDLE, no `done_o` pulse.
- With `STATUS_TX_GAP_EN` defined, load 18'h00003 → `data_o` 1, bubble, 2, then `done_o` in cycle k+4.
